// File: rtl/dsp_accum_pkg.sv
// Shared types and sizing helpers for the DSP window accumulator slice.
// Optional build macro used by this slice: ACC_SAT_EN (saturating adds).
package dsp_accum_pkg;

  localparam int DEF_DATA_W = 11;
  localparam int DEF_WINDOW = 4;
  localparam int DEF_ACC_W  = 13;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

  // Output slot occupancy: EMPTY means out_valid low, FULL means a window sum is waiting.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Smallest accumulator width that can hold any window sum without loss.
  function automatic int min_acc_w(input int data_w, input int window);
    return data_w + $clog2(window);
  endfunction

endpackage

// File: rtl/dsp_sat_add.sv
// Combinational accumulator adder: sign-extends a sample and adds it to the
// running sum. With ACC_SAT_EN defined the result clamps to the ACC_W range and
// ovf reports the clamp; otherwise the add wraps and ovf is constant 0.
module dsp_sat_add #(
  parameter int DATA_W = 11,
  parameter int ACC_W  = 13
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  logic signed [ACC_W-1:0] sample_ext;

  assign sample_ext = {{(ACC_W-DATA_W){sample[DATA_W-1]}}, sample};

`ifdef ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] wide;

  assign wide = {acc[ACC_W-1], acc} + {sample_ext[ACC_W-1], sample_ext};

  // One extra guard bit: when it disagrees with the result sign the add left the range.
  always_comb begin
    ovf = wide[ACC_W] ^ wide[ACC_W-1];
    sum = wide[ACC_W-1:0];
    if (ovf) begin
      sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  // Plain two's-complement add; wrapping is the intended behaviour in this build.
  always_comb begin
    sum = acc + sample_ext;
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/dsp_window_accumulator.sv
// Sums WINDOW accepted samples from the DSP stage and presents each window sum
// in a single valid/ready output slot that can absorb downstream backpressure.
// Build macro: ACC_SAT_EN selects saturating adds with a per-window overflow flag.
module dsp_window_accumulator
  import dsp_accum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WINDOW = DEF_WINDOW,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  input  logic                     clear,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  input  logic                     out_ready,
  output logic                     out_ovf
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  slot_state_t             slot;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;
  logic                    window_ovf;
  logic                    accept;
  logic                    last;

  // A full slot can still take a sample when the sink drains it this cycle.
  assign in_ready  = !clear && ((slot == SLOT_EMPTY) || out_ready);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CNT_LAST);
  assign out_valid = (slot == SLOT_FULL);

  dsp_sat_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc    (acc),
    .sample (in_data),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

`ifdef ACC_SAT_EN
  logic sat_seen;

  assign window_ovf = sat_seen | add_ovf;

  // Sticky record of any clamp within the current window; cleared alongside acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_seen <= 1'b0;
    end else if (clear || (accept && last)) begin
      sat_seen <= 1'b0;
    end else if (accept && add_ovf) begin
      sat_seen <= 1'b1;
    end
  end
`else
  // The wrapping adder never flags overflow, so out_ovf only ever loads 0.
  assign window_ovf = add_ovf;
`endif

  // Accumulator, sample counter and output slot state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      slot     <= SLOT_EMPTY;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= add_sum;
          cnt <= cnt + CNT_W'(1);
        end
      end

      case (slot)
        SLOT_EMPTY: begin
          if (accept && last) begin
            slot     <= SLOT_FULL;
            out_data <= add_sum;
            out_ovf  <= window_ovf;
          end
        end
        SLOT_FULL: begin
          if (accept && last) begin
            out_data <= add_sum;
            out_ovf  <= window_ovf;
          end else if (out_ready) begin
            slot <= SLOT_EMPTY;
          end
        end
        default: slot <= SLOT_EMPTY;
      endcase
    end
  end

endmodule
